// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   NOP_INSTR    : encoding of the all-zero sll $0,$0,0 used as a bubble
//   imem_state_t : instruction-memory control states (load / drain / run)
//   even_parity  : even-parity bit of a word, zero-extended to 64 bits
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IMEM_LOAD  = 2'd0,
    IMEM_DRAIN = 2'd1,
    IMEM_RUN   = 2'd2
  } imem_state_t;

  // Returns the bit that makes {bit, word} have an even number of ones.
  // Callers zero-extend narrower words; zero padding does not change the result.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port storage array for the instruction memory.
// One write port and one registered read port; the data array has no reset,
// so it maps onto block RAM.
// Ports:
//   clk    in   1        rising-edge clock
//   we     in   1        write enable
//   waddr  in   ADDR_W   write word address (caller guarantees < DEPTH)
//   wdata  in   WIDTH    write word
//   re     in   1        read enable; q holds its value when low
//   raddr  in   ADDR_W   read word address (caller guarantees < DEPTH)
//   q      out  WIDTH    registered read data
module imem_ram
  import mips_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_sync_loadable.sv
// Run-time loadable instruction memory for the 5-stage MIPS pipeline.
// Sits between the IF-stage PC register and the IF/ID register. A boot host
// writes the program in load mode; in run mode the IF stage fetches with a
// one-cycle registered read that supports stall (hold) and flush (bubble).
// Fetches of unloaded or out-of-range words return NOP_WORD with rd_valid=1,
// so the pipeline never sees X.
//
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word and report a sticky par_err output on any corrupted fetch.
//
// Ports:
//   clk       in   1       rising-edge clock
//   reset     in   1       synchronous, active-high
//   ld_mode   in   1       1 = load mode (fetch disabled), 0 = run
//   ld_we     in   1       load write strobe, only honoured in LOAD
//   ld_addr   in   ADDR_W  load word address
//   ld_data   in   DATA_W  load word
//   if_addr   in   ADDR_W  fetch word address (PC[ADDR_W+1:2])
//   if_stall  in   1       hold rd/rd_valid
//   if_flush  in   1       kill the fetch returned next cycle (beats stall)
//   rd        out  DATA_W  fetched instruction
//   rd_valid  out  1       rd holds a real fetch result
//   par_err   out  1       sticky parity error (IMEM_PARITY_EN only)
//   ld_busy   out  1       high in LOAD and DRAIN
module imem_sync_loadable
  import mips_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 64,
  parameter int                 ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_mode,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_stall,
  input  logic              if_flush,
  output logic [DATA_W-1:0] rd,
  output logic              rd_valid,
`ifdef IMEM_PARITY_EN
  output logic              par_err,
`endif
  output logic              ld_busy
);

`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  // DEPTH always fits in ADDR_W+1 bits, which lets the range checks work for
  // non-power-of-two depths without width mismatches.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  imem_state_t state_reg, state_next;

  logic [DEPTH-1:0] loaded_reg;
  logic             valid_reg, valid_next;
  // sel_reg: the RAM read register holds a loaded word for the current rd.
  logic             sel_reg, sel_next;

  logic             ld_in_range;
  logic             if_in_range;
  logic             wr_en;
  logic             run_active;
  logic             fetch_en;
  logic             fetch_hit;
  logic             hold;

  logic [RAM_W-1:0] ram_wdata;
  logic [RAM_W-1:0] ram_q;
  logic [DATA_W-1:0] ram_word;
  logic             par_bad;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ld_mode ? IMEM_LOAD : IMEM_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IMEM_LOAD:  if (!ld_mode) state_next = IMEM_DRAIN;
      // One settling cycle so a word written on the last load cycle is
      // visible to the first fetch.
      IMEM_DRAIN: state_next = IMEM_RUN;
      IMEM_RUN:   if (ld_mode) state_next = IMEM_LOAD;
      default:    state_next = IMEM_LOAD;
    endcase
  end

  assign ld_busy = (state_reg != IMEM_RUN);

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
  assign ld_in_range = ({1'b0, ld_addr} < DEPTH_C);
  // Reset kills any write presented in the same cycle.
  assign wr_en = !reset && (state_reg == IMEM_LOAD) && ld_we && ld_in_range;

`ifdef IMEM_PARITY_EN
  assign ram_wdata = {even_parity(64'(ld_data)), ld_data};
`else
  assign ram_wdata = ld_data;
`endif

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_loaded
      always_ff @(posedge clk) begin
        if (reset) begin
          loaded_reg[gi] <= 1'b0;
        end else if (wr_en && (ld_addr == ADDR_W'(gi))) begin
          loaded_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fetch path
  // ---------------------------------------------------------------------------
  assign if_in_range = ({1'b0, if_addr} < DEPTH_C);
  // A rising ld_mode in RUN aborts the fetch immediately, like a flush.
  assign run_active  = (state_reg == IMEM_RUN) && !ld_mode;
  assign fetch_en    = run_active && !if_flush && !if_stall;
  assign hold        = run_active && !if_flush && if_stall;
  assign fetch_hit   = fetch_en && if_in_range && loaded_reg[if_addr];

  always_comb begin
    valid_next = 1'b0;
    sel_next   = 1'b0;
    if (hold) begin
      valid_next = valid_reg;
      sel_next   = sel_reg;
    end else if (fetch_en) begin
      valid_next = 1'b1;
      sel_next   = fetch_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      sel_reg   <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      sel_reg   <= sel_next;
    end
  end

  // The RAM read register is only enabled on a hit, so during a stall or a
  // miss it keeps its value and sel_reg decides whether it reaches rd.
  imem_ram #(
    .WIDTH  (RAM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ld_addr),
    .wdata (ram_wdata),
    .re    (fetch_hit),
    .raddr (if_addr),
    .q     (ram_q)
  );

  assign ram_word = ram_q[DATA_W-1:0];

`ifdef IMEM_PARITY_EN
  logic par_err_reg;

  assign par_bad = sel_reg && (even_parity(64'(ram_word)) != ram_q[DATA_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_reg <= 1'b0;
    end else if (par_bad) begin
      par_err_reg <= 1'b1;
    end
  end

  // Report the error in the same cycle the corrupted word would have appeared.
  assign par_err = par_err_reg | par_bad;
`else
  assign par_bad = 1'b0;
`endif

  assign rd       = (sel_reg && !par_bad) ? ram_word : NOP_WORD;
  assign rd_valid = valid_reg;

endmodule

// File: tb/tb_imem_sync_loadable.sv
// Directed self-checking bench for imem_sync_loadable.
// Uses DEPTH=48 so that addresses 48..63 are representable but out of range.
module tb_imem_sync_loadable;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 48;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_mode;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] if_addr;
  logic              if_stall;
  logic              if_flush;
  logic [DATA_W-1:0] rd;
  logic              rd_valid;
  logic              ld_busy;
`ifdef IMEM_PARITY_EN
  logic              par_err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  imem_sync_loadable #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_mode  (ld_mode),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .if_addr  (if_addr),
    .if_stall (if_stall),
    .if_flush (if_flush),
    .rd       (rd),
    .rd_valid (rd_valid),
`ifdef IMEM_PARITY_EN
    .par_err  (par_err),
`endif
    .ld_busy  (ld_busy)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_mode = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    if_addr = '0; if_stall = 1'b0; if_flush = 1'b0;
    step();
    step();
    total_cnt++;
    if (rd !== 32'h0 || rd_valid !== 1'b0 || ld_busy !== 1'b1)
      $display("FAIL reset_state rd=%h valid=%b busy=%b, expected 00000000/0/1", rd, rd_valid, ld_busy);
    else begin pass_cnt++; $display("ok reset_state"); end
`ifdef IMEM_PARITY_EN
    total_cnt++;
    if (par_err !== 1'b0) $display("FAIL reset_par_err got %b expected 0", par_err);
    else begin pass_cnt++; $display("ok reset_par_err"); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_load_and_fetch();
    ld_we = 1'b1; ld_addr = 6'd0; ld_data = 32'h2002_000A; step();
    ld_addr = 6'd1; ld_data = 32'h2003_0003; step();
    ld_addr = 6'd50; ld_data = 32'h1234_5678; step();   // out of range, dropped
    ld_we = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b0 || ld_busy !== 1'b1)
      $display("FAIL load_outputs valid=%b busy=%b, expected 0/1", rd_valid, ld_busy);
    else begin pass_cnt++; $display("ok load_outputs"); end
    ld_mode = 1'b0;
    step();
    total_cnt++;
    if (ld_busy !== 1'b1 || rd_valid !== 1'b0)
      $display("FAIL drain_busy busy=%b valid=%b, expected 1/0", ld_busy, rd_valid);
    else begin pass_cnt++; $display("ok drain_busy"); end
    step();
    total_cnt++;
    if (ld_busy !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL run_entry busy=%b valid=%b, expected 0/0", ld_busy, rd_valid);
    else begin pass_cnt++; $display("ok run_entry"); end
    if_addr = 6'd0; step();
    total_cnt++;
    if (rd !== 32'h2002_000A || rd_valid !== 1'b1)
      $display("FAIL fetch0 rd=%h valid=%b, expected 2002000a/1", rd, rd_valid);
    else begin pass_cnt++; $display("ok fetch0"); end
    if_addr = 6'd1; step();
    total_cnt++;
    if (rd !== 32'h2003_0003 || rd_valid !== 1'b1)
      $display("FAIL fetch1 rd=%h valid=%b, expected 20030003/1", rd, rd_valid);
    else begin pass_cnt++; $display("ok fetch1"); end
  endtask

  task automatic test_unloaded();
    logic [ADDR_W-1:0] addrs [4];
    addrs = '{6'd5, 6'd48, 6'd50, 6'd63};
    for (int i = 0; i < 4; i++) begin
      if_addr = addrs[i];
      step();
      total_cnt++;
      if (rd !== 32'h0 || rd_valid !== 1'b1 || $isunknown(rd))
        $display("FAIL unloaded_fetch addr=%0d rd=%h valid=%b, expected 00000000/1", addrs[i], rd, rd_valid);
      else begin pass_cnt++; $display("ok unloaded_fetch addr=%0d", addrs[i]); end
    end
  endtask

  task automatic test_stall();
    if_addr = 6'd0; step();
    if_stall = 1'b1; if_addr = 6'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (rd !== 32'h2002_000A || rd_valid !== 1'b1)
        $display("FAIL stall_hold cyc=%0d rd=%h valid=%b, expected 2002000a/1", i, rd, rd_valid);
      else begin pass_cnt++; $display("ok stall_hold cyc=%0d", i); end
    end
    if_stall = 1'b0; step();
    total_cnt++;
    if (rd !== 32'h2003_0003 || rd_valid !== 1'b1)
      $display("FAIL stall_release rd=%h valid=%b, expected 20030003/1", rd, rd_valid);
    else begin pass_cnt++; $display("ok stall_release"); end
  endtask

  task automatic test_flush_stall();
    if_addr = 6'd0; if_flush = 1'b1; if_stall = 1'b1; step();
    total_cnt++;
    if (rd !== 32'h0 || rd_valid !== 1'b0)
      $display("FAIL flush_over_stall rd=%h valid=%b, expected 00000000/0", rd, rd_valid);
    else begin pass_cnt++; $display("ok flush_over_stall"); end
    if_flush = 1'b0; step();   // stall alone keeps the bubble
    total_cnt++;
    if (rd !== 32'h0 || rd_valid !== 1'b0)
      $display("FAIL stall_bubble rd=%h valid=%b, expected 00000000/0", rd, rd_valid);
    else begin pass_cnt++; $display("ok stall_bubble"); end
    if_stall = 1'b0; step();
    total_cnt++;
    if (rd !== 32'h2002_000A || rd_valid !== 1'b1)
      $display("FAIL after_flush rd=%h valid=%b, expected 2002000a/1", rd, rd_valid);
    else begin pass_cnt++; $display("ok after_flush"); end
  endtask

  task automatic test_run_write_and_abort();
    if_addr = 6'd1; ld_we = 1'b1; ld_addr = 6'd0; ld_data = 32'hDEAD_BEEF; step();
    ld_we = 1'b0; if_addr = 6'd0; step();
    total_cnt++;
    if (rd !== 32'h2002_000A || rd_valid !== 1'b1)
      $display("FAIL run_write_ignored rd=%h valid=%b, expected 2002000a/1", rd, rd_valid);
    else begin pass_cnt++; $display("ok run_write_ignored"); end
    ld_mode = 1'b1; step();
    total_cnt++;
    if (rd !== 32'h0 || rd_valid !== 1'b0 || ld_busy !== 1'b1)
      $display("FAIL ld_mode_abort rd=%h valid=%b busy=%b, expected 00000000/0/1", rd, rd_valid, ld_busy);
    else begin pass_cnt++; $display("ok ld_mode_abort"); end
  endtask

  task automatic test_reset_clears();
    // In LOAD: reset with a write pending; loaded bits must all clear.
    reset = 1'b1; ld_we = 1'b1; ld_addr = 6'd2; ld_data = 32'h1111_1111; step();
    reset = 1'b0; ld_we = 1'b0; ld_mode = 1'b0; step(); step();
    if_addr = 6'd0; step();
    total_cnt++;
    if (rd !== 32'h0 || rd_valid !== 1'b1)
      $display("FAIL reset_clears_loaded rd=%h valid=%b, expected 00000000/1", rd, rd_valid);
    else begin pass_cnt++; $display("ok reset_clears_loaded"); end
    if_addr = 6'd2; step();
    total_cnt++;
    if (rd !== 32'h0 || rd_valid !== 1'b1)
      $display("FAIL reset_drops_write rd=%h valid=%b, expected 00000000/1", rd, rd_valid);
    else begin pass_cnt++; $display("ok reset_drops_write"); end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    ld_mode = 1'b1; step();
    ld_we = 1'b1; ld_addr = 6'd1; ld_data = 32'h2003_0003; step();
    ld_we = 1'b0; ld_mode = 1'b0; step(); step();
    dut.u_ram.mem[1] = dut.u_ram.mem[1] ^ 33'h1;
    if_addr = 6'd1; step();
    total_cnt++;
    if (rd !== 32'h0 || rd_valid !== 1'b1 || par_err !== 1'b1)
      $display("FAIL parity_detect rd=%h valid=%b par=%b, expected 00000000/1/1", rd, rd_valid, par_err);
    else begin pass_cnt++; $display("ok parity_detect"); end
    if_addr = 6'd5; step(); step();
    total_cnt++;
    if (par_err !== 1'b1) $display("FAIL parity_sticky got %b expected 1", par_err);
    else begin pass_cnt++; $display("ok parity_sticky"); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_and_fetch();
    test_unloaded();
    test_stall();
    test_flush_stall();
    test_run_write_and_abort();
    test_reset_clears();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
